// File: rtl/seq_arith_pkg.sv
// Shared opcode/state encodings for the sequential arithmetic unit.
// Imported by the divider and the top level.
package seq_arith_pkg;

    typedef enum logic [3:0] {
        OP_LAND = 4'd0,
        OP_LOR  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_ADD  = 4'd5,
        OP_SUB  = 4'd6,
        OP_MUL  = 4'd7,
        OP_DIV  = 4'd8,
        OP_MOD  = 4'd9,
        OP_EQ   = 4'd10,
        OP_NE   = 4'd11,
        OP_LT   = 4'd12,
        OP_LE   = 4'd13,
        OP_GE   = 4'd14,
        OP_GT   = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/seq_arith_divider.sv
// Iterative restoring divider, one quotient bit per cycle, MSB first.
// The first iteration runs on the start cycle using the incoming operands.
module seq_arith_divider
    import seq_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] rem_s, quo_s, dvs_s;
    logic [WIDTH:0]   trial;
    logic             fits;

    always_comb begin
        rem_s  = start_i ? '0 : rem_q;
        quo_s  = start_i ? dividend_i : quo_q;
        dvs_s  = start_i ? divisor_i : dvs_q;
        trial  = {rem_s, quo_s[WIDTH-1]};
        fits   = trial >= {1'b0, dvs_s};
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start_i || busy_q) begin
            dvs_d = dvs_s;
            quo_d = {quo_s[WIDTH-2:0], fits};
            // Partial remainder stays below the divisor, so WIDTH bits suffice.
            rem_d = fits ? trial[WIDTH-1:0] - dvs_s : trial[WIDTH-1:0];
            if (start_i) begin
                cnt_d  = CW'(WIDTH - 1);
                busy_d = 1'b1;
            end else begin
                cnt_d  = cnt_q - CW'(1);
                busy_d = (cnt_q != CW'(1));
                done_d = (cnt_q == CW'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign quot_o = quo_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/seq_arith_unit.sv
// Handshaked WIDTH-bit unsigned arithmetic/compare unit with
// single-cycle ops and an iterative divide/modulo path.
module seq_arith_unit
    import seq_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero
);

    localparam int RW = 2 * WIDTH;

    state_e          state_q;
    logic [RW-1:0]   result_q;
    logic            dbz_q;
    logic            mod_q;

    logic            a_nz, b_nz;
    logic [WIDTH:0]  sum;
    logic [WIDTH-1:0] diff;
    logic [RW-1:0]   prod;
    logic [RW-1:0]   alu_res;
    logic            alu_dbz;

    logic            accept, div_start;
    logic            div_busy, div_done;
    logic [WIDTH-1:0] div_quot, div_rem;

    assign a_nz = |a;
    assign b_nz = |b;
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = a - b;
    assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    always_comb begin
        alu_res = '0;
        alu_dbz = 1'b0;
        unique case (op_e'(op))
            OP_LAND: alu_res = RW'(a_nz && b_nz);
            OP_LOR:  alu_res = RW'(a_nz || b_nz);
            OP_AND:  alu_res = RW'(a & b);
            OP_OR:   alu_res = RW'(a | b);
            OP_XOR:  alu_res = RW'(a ^ b);
            OP_ADD:  alu_res = RW'(sum);
            OP_SUB:  alu_res = RW'(diff);
            OP_MUL:  alu_res = prod;
            // Only the b==0 case is resolved here; b!=0 goes to the divider.
            OP_DIV: begin
                alu_res = b_nz ? '0 : {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                alu_dbz = !b_nz;
            end
            OP_MOD: begin
                alu_res = b_nz ? '0 : RW'(a);
                alu_dbz = !b_nz;
            end
            OP_EQ:   alu_res = RW'(a == b);
            OP_NE:   alu_res = RW'(a != b);
            OP_LT:   alu_res = RW'(a < b);
            OP_LE:   alu_res = RW'(a <= b);
            OP_GE:   alu_res = RW'(a >= b);
            OP_GT:   alu_res = RW'(a > b);
            default: alu_res = '0;
        endcase
    end

    assign in_ready  = !div_busy &&
                       ((state_q == ST_IDLE) ||
                        ((state_q == ST_DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign div_start = accept && is_div_op(op) && b_nz;

    seq_arith_divider #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start_i   (div_start),
        .dividend_i(a),
        .divisor_i (b),
        .busy_o    (div_busy),
        .done_o    (div_done),
        .quot_o    (div_quot),
        .rem_o     (div_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            dbz_q    <= 1'b0;
            mod_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        if (div_start) begin
                            state_q <= ST_DIV;
                            mod_q   <= (op == OP_MOD);
                        end else begin
                            state_q  <= ST_DONE;
                            result_q <= alu_res;
                            dbz_q    <= alu_dbz;
                        end
                    end else if ((state_q == ST_DONE) && out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        state_q  <= ST_DONE;
                        result_q <= mod_q ? RW'(div_rem) : RW'(div_quot);
                        dbz_q    <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid   = (state_q == ST_DONE);
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Scoreboard bench for seq_arith_unit: directed cases plus random traffic
// against a plain-arithmetic reference model.
module tb_seq_arith_unit;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [3:0]     op = '0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*W-1:0] result;
    logic           div_by_zero;

    seq_arith_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] res;
        logic           dbz;
        int             lat;
        int             acc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   div_acc = -1;
    bit   rand_rdy = 1'b0;
    bit   presenting = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic void model(input int o, input longint x,
                                  input longint y, output longint r,
                                  output bit z);
        longint m;
        m = longint'(1) << W;
        z = 1'b0;
        r = 0;
        case (o)
            0:  r = (x != 0 && y != 0) ? 1 : 0;
            1:  r = (x != 0 || y != 0) ? 1 : 0;
            2:  r = x & y;
            3:  r = x | y;
            4:  r = x ^ y;
            5:  r = x + y;
            6:  r = (x - y + m) % m;
            7:  r = x * y;
            8:  begin
                    if (y == 0) begin r = m - 1; z = 1'b1; end
                    else r = x / y;
                end
            9:  begin
                    if (y == 0) begin r = x; z = 1'b1; end
                    else r = x % y;
                end
            10: r = (x == y) ? 1 : 0;
            11: r = (x != y) ? 1 : 0;
            12: r = (x < y) ? 1 : 0;
            13: r = (x <= y) ? 1 : 0;
            14: r = (x >= y) ? 1 : 0;
            default: r = (x > y) ? 1 : 0;
        endcase
    endfunction

    // Called just after a rising edge; returns just after the accept edge.
    task automatic send(input int o, input int x, input int y);
        longint r;
        bit     z;
        exp_t   e;
        int     t;
        t = 0;
        op = 4'(o);
        a = W'(x);
        b = W'(y);
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 100);
        chk("accept", 32'(in_ready), 32'd1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        model(o, longint'(x), longint'(y), r, z);
        e.res = r[2*W-1:0];
        e.dbz = z;
        e.lat = ((o == 8 || o == 9) && y != 0) ? W + 1 : 1;
        e.acc = cyc;
        if (e.lat > 1) div_acc = cyc;
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() > 0 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            presenting = 1'b0;
        end else begin
            if (div_acc >= 0 && cyc > div_acc && !out_valid)
                chk("in_ready_during_div", 32'(in_ready), 32'd0);
            if (out_valid) begin
                if (div_acc >= 0 && cyc > div_acc) div_acc = -1;
                if (q.size() == 0) begin
                    chk("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    e = q[0];
                    if (!presenting)
                        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                    presenting = 1'b1;
                    chk("result", 32'(result), 32'(e.res));
                    chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                    if (out_ready) begin
                        void'(q.pop_front());
                        presenting = 1'b0;
                    end
                end
            end else begin
                presenting = 1'b0;
            end
        end
    end

    initial begin
        int c0;
        int o, x, y;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        send(5, 200, 100);
        send(6, 3, 5);
        send(7, 255, 255);
        send(12, 3, 7);
        send(14, 3, 7);
        send(0, 0, 9);
        send(8, 200, 7);
        send(9, 200, 7);
        send(8, 50, 0);
        send(9, 50, 0);
        drain();

        out_ready = 1'b0;
        send(4, 8'hA5, 8'h3C);
        repeat (5) begin
            @(negedge clk);
            chk("in_ready_backpressure", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        c0 = cyc;
        send(3, 8'h0F, 8'h30);
        chk("back_to_back", 32'(cyc - c0), 32'd1);
        drain();

        send(8, 200, 7);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        div_acc = -1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        chk("rst_div_out_valid", 32'(out_valid), 32'd0);
        chk("rst_div_result", 32'(result), 32'd0);
        chk("rst_div_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        send(5, 1, 1);
        drain();

        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            o = int'($urandom_range(0, 15));
            x = int'($urandom_range(0, 255));
            y = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(o, x, y);
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_arith_unit.md
Name: seq_arith_unit

Overview:
Parametrised, handshaked successor to the team's 4-bit combinational arithmetic/compare block. It performs one unsigned operation per transaction on WIDTH-bit operands, selected by a 4-bit opcode. It adds the division and modulo operations the earlier block lacks, using an iterative restoring divider. It sits between an operand producer and a result consumer, with valid/ready on both sides.

Parameters:
WIDTH, 8, operand width in bits (>=2); result port is 2*WIDTH bits.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand/opcode presented
in_ready  output  1  unit accepts a transaction this cycle
op  input  4  opcode (encoding below)
a  input  WIDTH  operand A (unsigned)
b  input  WIDTH  operand B (unsigned)
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
result  output  2*WIDTH  zero-extended result
div_by_zero  output  1  qualifies result; set for DIV/MOD with b==0

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous, active-high. On reset: state=IDLE, out_valid=0, result=0, div_by_zero=0. in_ready follows state (1 in IDLE).
- Reset mid-divide or mid-hold discards the transaction; no output is produced.
- Opcodes: 0 LAND (a!=0 && b!=0), 1 LOR, 2 AND, 3 OR, 4 XOR, 5 ADD, 6 SUB, 7 MUL, 8 DIV, 9 MOD, 10 EQ, 11 NE, 12 LT, 13 LE, 14 GE, 15 GT. All 16 codes are defined.
- Width rules:
  - Logical and compare ops yield 1 bit, zero-extended.
  - AND/OR/XOR yield WIDTH bits.
  - ADD yields WIDTH+1 bits; the carry is kept.
  - SUB yields WIDTH bits, mod 2^WIDTH; no borrow is exposed.
  - MUL yields the full 2*WIDTH bits.
  - DIV yields the quotient; MOD yields the remainder (both WIDTH bits).
- Handshake: a transaction is accepted when in_valid && in_ready. in_ready = (state==IDLE) || (state==DONE && out_ready), which allows back-to-back throughput of one op per cycle for single-cycle ops.
- FSM:
  - IDLE -> DONE on accept of ops 0-7 or 10-15; result is registered, so latency is 1 cycle (out_valid rises in the cycle after accept).
  - IDLE -> DIV on accept of op 8/9 with b!=0. Performs WIDTH restoring iterations, one quotient bit per cycle, MSB first. Then -> DONE, so out_valid rises WIDTH+1 cycles after accept.
  - Op 8/9 with b==0: goes directly to DONE with latency 1. result = all-ones quotient (DIV) or a (MOD), and div_by_zero=1.
  - DONE: out_valid=1; result and div_by_zero are held stable while out_ready=0. On out_ready: with a simultaneous new accept, take the next transition as from IDLE; otherwise go to IDLE with out_valid=0.
  - DIV: in_ready=0; in_valid is ignored.
- div_by_zero is 0 for every other result. Operands are captured at accept, so later input changes have no effect.

Decomposition:
- Package seq_arith_pkg holds:
  - op_e enum (4-bit opcode encodings above);
  - state_e enum (IDLE, DIV, DONE);
  - is_div_op() helper function.
- One sub-module, seq_arith_divider: start/busy/done, WIDTH parameter, restoring iteration producing quotient and remainder.
- The top level holds the FSM, the combinational single-cycle datapath and the output register.

Test Plan:
- WIDTH=8: ADD a=200 b=100 -> result=300 (0x012C) one cycle after accept; SUB a=3 b=5 -> 0x00FE.
- MUL a=255 b=255 -> result=0xFE01; LT a=3 b=7 -> 1; GE a=3 b=7 -> 0; LAND a=0 b=9 -> 0.
- DIV a=200 b=7 -> result=28, out_valid exactly 9 cycles after accept; MOD a=200 b=7 -> 4; in_ready=0 throughout the divide.
- DIV a=50 b=0 -> result=0x00FF, div_by_zero=1, latency 1; MOD a=50 b=0 -> 50, div_by_zero=1.
- Backpressure: hold out_ready=0 for 5 cycles after an XOR result -> result stable and in_ready=0; then out_ready=1 with in_valid=1 (OR op) -> back-to-back accept, next result valid on the following cycle.
- Assert rst during cycle 4 of a DIV -> next cycle out_valid=0, result=0, in_ready=1; a fresh ADD 1+1 then returns 2.
